spi_bus_arbiter: RTL

Two-master arbiter for the shared SPI pins that drive the boot flash (CS0) and the SD card (CS1). It lets the SoC SPI master and a second requester, such as an SD-card block-transfer engine or a boot loader, take turns on the single SCK/MOSI/MISO/CS bundle. Ownership is granted by request/grant handshake with round-robin fairness. An owner is never pre-empted while any chip-select is asserted, and the bus is held idle for a programmable gap between owners. The block sits between the masters and the top-level pin assignments for flash and SD card.

---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/spi_bus_arbiter_if.sv | 26 ++
 rtl/spi_arb_mux.sv | 43 ++++
 rtl/spi_bus_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-master SPI pin arbiter.
// Imported by the arbiter top and its pin multiplexer.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic SPI_IDLE_CLK  = 1'b0;
  localparam logic SPI_IDLE_MOSI = 1'b1;

  localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// One SPI bundle: SCK, MOSI and active-low CS toward a slave, MISO back.
// The master modport drives the bus and the slave modport receives it.
interface spi_bus_arbiter_if #(
  parameter int NUM_CS = 2
);

  logic              sclk;
  logic              mosi;
  logic [NUM_CS-1:0] cs;
  logic              miso;

  modport master (
    output sclk,
    output mosi,
    output cs,
    input  miso
  );

  modport slave (
    input  sclk,
    input  mosi,
    input  cs,
    output miso
  );

endinterface

// File: rtl/spi_arb_mux.sv
// Owner/idle multiplexer for the shared SPI pins plus MISO fan-back.
// Select comes only from registered arbiter state, never from req/gnt.
module spi_arb_mux
  import spi_arb_pkg::*;
#(
  parameter int NUM_CS = 2
) (
  input  state_t              state_i,
  spi_bus_arbiter_if.slave    m0_if,
  spi_bus_arbiter_if.slave    m1_if,
  spi_bus_arbiter_if.master   pin_if
);

  logic own0;
  logic own1;

  assign own0 = (state_i == GRANT0);
  assign own1 = (state_i == GRANT1);

  always_comb begin
    pin_if.sclk = SPI_IDLE_CLK;
    pin_if.mosi = SPI_IDLE_MOSI;
    pin_if.cs   = '1;
    unique case (1'b1)
      own0: begin
        pin_if.sclk = m0_if.sclk;
        pin_if.mosi = m0_if.mosi;
        pin_if.cs   = m0_if.cs;
      end
      own1: begin
        pin_if.sclk = m1_if.sclk;
        pin_if.mosi = m1_if.mosi;
        pin_if.cs   = m1_if.cs;
      end
      default: ;
    endcase
  end

  // A master that does not own the bus sees an idle-high MISO
  assign m0_if.miso = own0 ? pin_if.miso : 1'b1;
  assign m1_if.miso = own1 ? pin_if.miso : 1'b1;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin two-master arbiter for the shared flash/SD SPI pins.
// Owners are never pre-empted while any CS is low; a gap follows release.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_CS     = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m1_req_i,
  output logic              m0_gnt_o,
  output logic              m1_gnt_o,
  input  logic              m0_spi_clk_i,
  input  logic              m1_spi_clk_i,
  input  logic              m0_spi_mosi_i,
  input  logic              m1_spi_mosi_i,
  input  logic [NUM_CS-1:0] m0_spi_cs_i,
  input  logic [NUM_CS-1:0] m1_spi_cs_i,
  output logic              m0_spi_miso_o,
  output logic              m1_spi_miso_o,
  output logic              spi_clk_o,
  output logic              spi_mosi_o,
  output logic [NUM_CS-1:0] spi_cs_o,
  input  logic              spi_miso_i,
  output logic              owner_o,
  output logic              busy_o
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  state_t                 state_q, state_d;
  logic [GAP_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   owner_q, owner_d;

  spi_bus_arbiter_if #(.NUM_CS(NUM_CS)) m0_bus ();
  spi_bus_arbiter_if #(.NUM_CS(NUM_CS)) m1_bus ();
  spi_bus_arbiter_if #(.NUM_CS(NUM_CS)) pin_bus ();

  assign m0_bus.sclk   = m0_spi_clk_i;
  assign m0_bus.mosi   = m0_spi_mosi_i;
  assign m0_bus.cs     = m0_spi_cs_i;
  assign m1_bus.sclk   = m1_spi_clk_i;
  assign m1_bus.mosi   = m1_spi_mosi_i;
  assign m1_bus.cs     = m1_spi_cs_i;
  assign pin_bus.miso  = spi_miso_i;

  assign m0_spi_miso_o = m0_bus.miso;
  assign m1_spi_miso_o = m1_bus.miso;
  assign spi_clk_o     = pin_bus.sclk;
  assign spi_mosi_o    = pin_bus.mosi;
  assign spi_cs_o      = pin_bus.cs;

  spi_arb_mux #(
    .NUM_CS (NUM_CS)
  ) u_mux (
    .state_i (state_q),
    .m0_if   (m0_bus.slave),
    .m1_if   (m1_bus.slave),
    .pin_if  (pin_bus.master)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        // On a tie, the master that did not own the bus last wins
        if (m0_req_i && (!m1_req_i || last_q)) begin
          state_d = GRANT0;
          owner_d = 1'b0;
        end else if (m1_req_i) begin
          state_d = GRANT1;
          owner_d = 1'b1;
        end
      end
      GRANT0: begin
        if (!m0_req_i && (&m0_spi_cs_i)) begin
          last_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GRANT1: begin
        if (!m1_req_i && (&m1_spi_cs_i)) begin
          last_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_gnt_o = (state_q == GRANT0);
  assign m1_gnt_o = (state_q == GRANT1);
  assign busy_o   = (state_q != IDLE);
  assign owner_o  = owner_q;

endmodule
